systolic_result_drain: RTL and testbench

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

---
 rtl/systolic_result_drain.sv | 103 ++++++++++
 tb/tb_systolic_result_drain.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// Drains a 3x3 systolic array result as a ready/valid byte stream, one beat per element.
// A frame is latched on CAPTURE and streamed in row-major order; CAPTUREs arriving mid-frame flag OVERRUN.
module systolic_result_drain #(
    parameter int NUM_RESULTS = 9
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CAPTURE,
    input  logic [7:0] M1_in,
    input  logic [7:0] M2_in,
    input  logic [7:0] M3_in,
    input  logic [7:0] M4_in,
    input  logic [7:0] M5_in,
    input  logic [7:0] M6_in,
    input  logic [7:0] M7_in,
    input  logic [7:0] M8_in,
    input  logic [7:0] M9_in,
    input  logic       OUT_READY,
    output logic [7:0] OUT_DATA,
    output logic       OUT_VALID,
    output logic [3:0] OUT_INDEX,
    output logic       OUT_LAST,
    output logic       BUSY,
    output logic       DONE,
    output logic       OVERRUN
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;
    localparam logic [3:0] LAST_INDEX = 4'(NUM_RESULTS - 1);

    logic [0:0] state;
    logic [7:0] buffer  [0:8];
    logic [7:0] results [0:8];
    logic [3:0] index;
    logic       doneFlag;
    logic       overrunFlag;
    logic       streaming;

    always_comb begin
        results[0] = M1_in;
        results[1] = M2_in;
        results[2] = M3_in;
        results[3] = M4_in;
        results[4] = M5_in;
        results[5] = M6_in;
        results[6] = M7_in;
        results[7] = M8_in;
        results[8] = M9_in;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            index       <= 4'd0;
            doneFlag    <= 1'b0;
            overrunFlag <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                buffer[i] <= 8'd0;
            end
        end else begin
            doneFlag <= 1'b0;
            case (state)
                IDLE: begin
                    if (CAPTURE) begin
                        for (int i = 0; i < 9; i++) begin
                            buffer[i] <= results[i];
                        end
                        index <= 4'd0;
                        state <= STREAM;
                    end
                end
                default: begin
                    // A mid-frame capture never touches the buffer; it only raises the sticky flag.
                    if (CAPTURE) begin
                        overrunFlag <= 1'b1;
                    end
                    if (OUT_READY) begin
                        if (index == LAST_INDEX) begin
                            state    <= IDLE;
                            index    <= 4'd0;
                            doneFlag <= 1'b1;
                        end else begin
                            index <= index + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        streaming = (state == STREAM);
        OUT_VALID = streaming;
        BUSY      = streaming;
        OUT_DATA  = streaming ? buffer[index] : 8'd0;
        OUT_INDEX = streaming ? index : 4'd0;
        OUT_LAST  = streaming && (index == LAST_INDEX);
        DONE      = doneFlag;
        OVERRUN   = overrunFlag;
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: vector table for full frames plus hand sequences
// for overrun, mid-frame reset, back-to-back frames and input isolation.
module tb_systolic_result_drain;

    logic       CLK;
    logic       RESET;
    logic       CAPTURE;
    logic [7:0] m [0:8];
    logic       OUT_READY;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic [3:0] OUT_INDEX;
    logic       OUT_LAST;
    logic       BUSY;
    logic       DONE;
    logic       OVERRUN;

    int compared;
    int mismatched;

    systolic_result_drain #(.NUM_RESULTS(9)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .CAPTURE(CAPTURE),
        .M1_in(m[0]),
        .M2_in(m[1]),
        .M3_in(m[2]),
        .M4_in(m[3]),
        .M5_in(m[4]),
        .M6_in(m[5]),
        .M7_in(m[6]),
        .M8_in(m[7]),
        .M9_in(m[8]),
        .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_INDEX(OUT_INDEX),
        .OUT_LAST(OUT_LAST),
        .BUSY(BUSY),
        .DONE(DONE),
        .OVERRUN(OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       cap;
        logic       rdy;
        logic       expValid;
        logic [7:0] expData;
        logic [3:0] expIndex;
        logic       expLast;
        logic       expDone;
        logic       expOverrun;
    } vec_t;

    vec_t vecs [0:63];
    int   numVecs;

    task automatic addVec(input logic rst, input logic cap, input logic rdy, input logic v,
                          input logic [7:0] d, input logic [3:0] idx, input logic l,
                          input logic dn, input logic ov);
        vecs[numVecs].rst        = rst;
        vecs[numVecs].cap        = cap;
        vecs[numVecs].rdy        = rdy;
        vecs[numVecs].expValid   = v;
        vecs[numVecs].expData    = d;
        vecs[numVecs].expIndex   = idx;
        vecs[numVecs].expLast    = l;
        vecs[numVecs].expDone    = dn;
        vecs[numVecs].expOverrun = ov;
        numVecs++;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic cap, input logic rdy);
        @(negedge CLK);
        RESET     = rst;
        CAPTURE   = cap;
        OUT_READY = rdy;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic v, input logic [7:0] d,
                         input logic [3:0] idx, input logic l, input logic dn, input logic ov);
        logic [16:0] act;
        logic [16:0] exp;
        act = {OUT_VALID, OUT_DATA, OUT_INDEX, OUT_LAST, BUSY, DONE, OVERRUN};
        exp = {v, d, idx, l, v, dn, ov};
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got v=%b d=%02h i=%0d l=%b b=%b dn=%b ov=%b, want v=%b d=%02h i=%0d l=%b b=%b dn=%b ov=%b",
                     name, OUT_VALID, OUT_DATA, OUT_INDEX, OUT_LAST, BUSY, DONE, OVERRUN,
                     v, d, idx, l, v, dn, ov);
        end
    endtask

    task automatic setM(input logic [7:0] base);
        for (int i = 0; i < 9; i++) begin
            m[i] = base + 8'(i);
        end
    endtask

    initial begin
        int idx;
        logic rdy;
        logic [7:0] pat [0:8];

        compared   = 0;
        mismatched = 0;
        numVecs    = 0;
        RESET      = 1'b1;
        CAPTURE    = 1'b0;
        OUT_READY  = 1'b0;
        setM(8'd1);

        // Reset beats a simultaneous capture; ready in idle does nothing.
        addVec(1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        addVec(0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        // Full frame 1..9 with ready held high.
        addVec(0, 1, 1, 1, 8'd1, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            addVec(0, 0, 1, 1, 8'(k + 1), 4'(k), (k == 8), 0, 0);
        end
        addVec(0, 0, 1, 0, 8'h00, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        // Same frame with ready toggling 1,0,0,1,...
        addVec(0, 1, 0, 1, 8'd1, 0, 0, 0, 0);
        idx = 0;
        for (int j = 0; j < 40; j++) begin
            rdy = ((j % 4) == 0) || ((j % 4) == 3);
            if (rdy && idx == 8) begin
                addVec(0, 0, 1, 0, 8'h00, 0, 0, 1, 0);
                break;
            end
            if (rdy) idx++;
            addVec(0, 0, rdy, 1, 8'(idx + 1), 4'(idx), (idx == 8), 0, 0);
        end
        addVec(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);

        for (int n = 0; n < numVecs; n++) begin
            step(vecs[n].rst, vecs[n].cap, vecs[n].rdy);
            check($sformatf("vec%0d", n), vecs[n].expValid, vecs[n].expData, vecs[n].expIndex,
                  vecs[n].expLast, vecs[n].expDone, vecs[n].expOverrun);
        end

        // Overrun: capture 0xAA.. while beat 4 is presented; original frame must finish intact.
        step(0, 1, 1);
        check("ovr_beat0", 1, 8'd1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 1);
            check($sformatf("ovr_beat%0d", k), 1, 8'(k + 1), 4'(k), 0, 0, 0);
        end
        setM(8'hAA);
        step(0, 1, 1);
        check("ovr_hit", 1, 8'd6, 5, 0, 0, 1);
        for (int k = 6; k <= 8; k++) begin
            step(0, 0, 1);
            check($sformatf("ovr_tail%0d", k), 1, 8'(k + 1), 4'(k), (k == 8), 0, 1);
        end
        step(0, 0, 1);
        check("ovr_done", 0, 8'h00, 0, 0, 1, 1);
        step(0, 0, 0);
        check("ovr_sticky", 0, 8'h00, 0, 0, 0, 1);

        // Capture on the edge where beat 8 transfers is ignored but flags overrun.
        step(1, 0, 0);
        check("rst_clears_ovr", 0, 8'h00, 0, 0, 0, 0);
        setM(8'd1);
        step(0, 1, 1);
        for (int k = 1; k <= 8; k++) step(0, 0, 1);
        check("last8_shown", 1, 8'd9, 8, 1, 0, 0);
        setM(8'h40);
        step(0, 1, 1);
        check("cap_at_last", 0, 8'h00, 0, 0, 1, 1);
        step(0, 0, 1);
        check("cap_at_last_idle", 0, 8'h00, 0, 0, 0, 1);

        // Reset mid-frame at beat 5: no DONE, then a new frame starts from index 0.
        step(1, 0, 0);
        setM(8'd1);
        step(0, 1, 1);
        for (int k = 1; k <= 5; k++) step(0, 0, 1);
        check("mid_beat5", 1, 8'd6, 5, 0, 0, 0);
        step(1, 0, 1);
        check("mid_rst", 0, 8'h00, 0, 0, 0, 0);
        step(0, 0, 1);
        check("mid_no_done", 0, 8'h00, 0, 0, 0, 0);
        setM(8'h21);
        step(0, 1, 0);
        check("mid_restart", 1, 8'h21, 0, 0, 0, 0);
        step(0, 0, 1);
        check("mid_restart1", 1, 8'h22, 1, 0, 0, 0);

        // Back-to-back: capture 0x10.. in the DONE cycle.
        step(1, 0, 0);
        setM(8'd1);
        step(0, 1, 1);
        for (int k = 1; k <= 9; k++) step(0, 0, 1);
        check("b2b_done", 0, 8'h00, 0, 0, 1, 0);
        setM(8'h10);
        step(0, 1, 1);
        check("b2b_start", 1, 8'h10, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 1);
            check($sformatf("b2b_beat%0d", k), 1, 8'h10 + 8'(k), 4'(k), (k == 8), 0, 0);
        end
        step(0, 0, 1);
        check("b2b_done2", 0, 8'h00, 0, 0, 1, 0);

        // Pattern frame; inputs change right after capture and must not leak through.
        for (int i = 0; i < 9; i++) begin
            pat[i] = (i % 3 == 0) ? 8'hFF : ((i % 3 == 1) ? 8'h00 : 8'h80);
            m[i]   = pat[i];
        end
        step(0, 1, 0);
        for (int i = 0; i < 9; i++) m[i] = 8'h5A;
        check("pat_beat0", 1, pat[0], 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 1);
            check($sformatf("pat_beat%0d", k), 1, pat[k], 4'(k), (k == 8), 0, 0);
        end
        step(0, 0, 1);
        for (int i = 0; i < 9; i++) m[i] = 8'hC3;
        step(0, 0, 1);
        check("pat_idle_isolated", 0, 8'h00, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
